// File: rtl/cmd_stream_caster_if.sv
// cmd_stream_caster_if: byte-in / record-out handshake bundle of cmd_stream_caster.
// Ports: in_data/in_kind/in_valid/in_ready carry the wire-format byte stream,
// out_data/out_kind/out_sat/out_valid/out_ready carry the converted record.
// master = producer/consumer side, slave = caster side.
interface cmd_stream_caster_if #(
   parameter int OUT_INT_BITS  = 11,
   parameter int OUT_FRAC_BITS = 14,
   parameter int COLOR_BITS    = 4
);
   localparam int W      = OUT_INT_BITS + OUT_FRAC_BITS;
   localparam int TRI_W  = 9 * W + 9 * COLOR_BITS;
   localparam int MI_W   = 8 + 12 * W;
   localparam int DATA_W = (TRI_W > MI_W) ? TRI_W : MI_W;
   logic [7:0]        in_data;
   logic              in_kind;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_kind;
   logic              out_sat;
   logic              out_valid;
   logic              out_ready;
   modport master (output in_data, in_kind, in_valid, out_ready,
                   input  in_ready, out_data, out_kind, out_sat, out_valid);
   modport slave  (input  in_data, in_kind, in_valid, out_ready,
                   output in_ready, out_data, out_kind, out_sat, out_valid);
endinterface

// File: rtl/cmd_stream_caster.sv
// cmd_stream_caster: assembles Q16.16/RGB565 triangle or model-instance records
// from a byte stream and converts each field to OUT_INT_BITS.OUT_FRAC_BITS fixed
// point and COLOR_BITS per channel.
// Ports: clk, reset (async, active-high), bus (cmd_stream_caster_if.slave).
// Macro CMD_CAST_SATURATE_EN: saturate out-of-range fixed fields and flag out_sat;
// when undefined, fields wrap and out_sat is 0.
module cmd_stream_caster #(
   parameter int OUT_INT_BITS  = 11,
   parameter int OUT_FRAC_BITS = 14,
   parameter int COLOR_BITS    = 4
) (
   input logic clk,
   input logic reset,
   cmd_stream_caster_if.slave bus
);
   localparam int W      = OUT_INT_BITS + OUT_FRAC_BITS;
   localparam int C      = COLOR_BITS;
   localparam int VW     = 3 * C + 3 * W;
   localparam int TRI_W  = 9 * W + 9 * C;
   localparam int MI_W   = 8 + 12 * W;
   localparam int DATA_W = (TRI_W > MI_W) ? TRI_W : MI_W;
   localparam int SH     = 16 - OUT_FRAC_BITS;
   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
   state_t              state_q, state_d;
   logic [3:0]          fld_q, fld_d;
   logic [1:0]          bcnt_q, bcnt_d;
   logic [31:0]         sh_q, sh_d;
   logic                kind_q, kind_d;
   logic [DATA_W-1:0]   data_q, data_d, slot, base;
   logic [31:0]         word;
   logic signed [31:0]  shifted;
   logic [W-1:0]        fx;
   logic [3*C-1:0]      colv;
   logic                kind, acc, is_col, is_id, last_b, last_f;
   int                  lsb;
   assign word    = {sh_q[23:0], bus.in_data};
   assign shifted = $signed(word) >>> SH;
   assign colv    = {word[15 -: C], word[10 -: C], word[4 -: C]};
   // in_kind only matters on the first byte; afterwards the latched kind rules
   assign kind    = (state_q == IDLE) ? bus.in_kind : kind_q;
   assign acc     = bus.in_valid && (state_q != HOLD);
   assign is_col  = !kind && (fld_q[1:0] == 2'd0);
   assign is_id   = kind && (fld_q == 4'd0);
   assign last_b  = bcnt_q == (is_id ? 2'd0 : is_col ? 2'd1 : 2'd3);
   assign last_f  = fld_q == (kind ? 4'd12 : 4'd11);
`ifdef CMD_CAST_SATURATE_EN
   logic signed [31:0] hi;
   logic               ovf, sat_q, sat_d;
   always_comb begin
      hi    = shifted >>> (W - 1);
      ovf   = (|hi) && !(&hi);
      fx    = ovf ? (shifted[31] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : W'(shifted);
      sat_d = sat_q;
      if (acc)
         sat_d = ((state_q != IDLE) && sat_q) || (last_b && !is_id && !is_col && ovf);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) sat_q <= 1'b0;
      else       sat_q <= sat_d;
   assign bus.out_sat = sat_q;
`else
   assign fx          = W'(shifted);
   assign bus.out_sat = 1'b0;
`endif
   always_comb begin
      // slot offsets from the top of the record: fields are packed MSB-first
      lsb     = kind ? MI_W - 8 - int'(fld_q) * W
                     : TRI_W - int'(fld_q[3:2]) * VW - 3 * C - int'(fld_q[1:0]) * W;
      slot    = is_id ? DATA_W'(word[7:0]) : is_col ? DATA_W'(colv) : DATA_W'(fx);
      base    = (state_q == IDLE) ? '0 : data_q;
      state_d = state_q;
      fld_d   = fld_q;
      bcnt_d  = bcnt_q;
      sh_d    = sh_q;
      kind_d  = kind_q;
      data_d  = data_q;
      if (acc) begin
         sh_d    = word;
         kind_d  = kind;
         data_d  = last_b ? (base | (slot << lsb)) : base;
         bcnt_d  = last_b ? 2'd0 : bcnt_q + 2'd1;
         fld_d   = last_b ? (last_f ? 4'd0 : fld_q + 4'd1) : fld_q;
         state_d = (last_b && last_f) ? HOLD : COLLECT;
      end else if ((state_q == HOLD) && bus.out_ready)
         state_d = IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         fld_q   <= '0;
         bcnt_q  <= '0;
         sh_q    <= '0;
         kind_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         fld_q   <= fld_d;
         bcnt_q  <= bcnt_d;
         sh_q    <= sh_d;
         kind_q  <= kind_d;
         data_q  <= data_d;
      end
   assign bus.in_ready  = state_q != HOLD;
   assign bus.out_valid = state_q == HOLD;
   assign bus.out_data  = data_q;
   assign bus.out_kind  = kind_q;
endmodule
